// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - CDB arbiter shared widths, result record type and helpers
package cdb_pkg;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;
   localparam int CDB_W  = TAG_W + DATA_W;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdb_t;

   // Tag 0 is the ROB sink slot, so an all-zero bus is harmless downstream.
   localparam cdb_t CDB_IDLE = '0;

   function automatic logic [TAG_W-1:0] tag_of(input logic [CDB_W-1:0] word);
      cdb_t r;
      r = cdb_t'(word);
      return r.tag;
   endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - combinational round-robin picker: first set mask bit at or after start
module cdb_rr_pick #(
   parameter int N     = 6,
   parameter int PTR_W = 3
) (
   input  logic [N-1:0]     mask,
   input  logic [PTR_W-1:0] start,
   output logic [N-1:0]     pick,
   output logic [PTR_W-1:0] idx,
   output logic             found
);

   always_comb begin
      int j;
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(start) + k;
         if (j >= N) j = j - N;
         if (!found && mask[j]) begin
            found   = 1'b1;
            pick[j] = 1'b1;
            idx     = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter granting up to NUM_CDB results per cycle onto the CDBs
// Optional per-requester stall counters enabled by defining CDB_ARB_PERF_EN.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = 6,
   parameter int NUM_CDB = 3
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             kill,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0][CDB_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_CDB-1:0][CDB_W-1:0]    cdb_out,
   output logic [NUM_CDB-1:0]               cdb_valid
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [NUM_REQ-1:0][15:0]         perf_stall_cnt
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   next_ptr;
   logic [PTR_W-1:0]   last_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any_grant;

   logic [NUM_REQ-1:0] stage_mask [NUM_CDB+1];
   logic [NUM_REQ-1:0] stage_pick [NUM_CDB];
   logic [PTR_W-1:0]   stage_idx  [NUM_CDB];
   logic               stage_found[NUM_CDB];

   assign stage_mask[0] = req_valid;

   // Every stage scans from rr_ptr; earlier picks are masked off, so stage k
   // lands on the k-th valid requester in round-robin order.
   for (genvar k = 0; k < NUM_CDB; k++) begin : g_stage
      cdb_rr_pick #(
         .N     (NUM_REQ),
         .PTR_W (PTR_W)
      ) u_pick (
         .mask  (stage_mask[k]),
         .start (rr_ptr),
         .pick  (stage_pick[k]),
         .idx   (stage_idx[k]),
         .found (stage_found[k])
      );
      assign stage_mask[k+1] = stage_mask[k] & ~stage_pick[k];
   end

   always_comb begin
      grant     = '0;
      last_idx  = rr_ptr;
      any_grant = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         grant = grant | stage_pick[k];
         if (stage_found[k]) begin
            last_idx  = stage_idx[k];
            any_grant = 1'b1;
         end
      end
      next_ptr = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
   end

   assign req_ready = (reset_n && !kill) ? grant : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr    <= '0;
         cdb_out   <= '0;
         cdb_valid <= '0;
      end else begin
         if (!kill && any_grant) rr_ptr <= next_ptr;
         for (int k = 0; k < NUM_CDB; k++) begin
            if (stage_found[k] && !kill) begin
               cdb_out[k]   <= req_data[stage_idx[k]];
               cdb_valid[k] <= 1'b1;
            end else begin
               cdb_out[k]   <= CDB_IDLE;
               cdb_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef CDB_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_ready[i] && perf_stall_cnt[i] != 16'hFFFF)
               perf_stall_cnt[i] <= perf_stall_cnt[i] + 16'd1;
         end
      end
   end
`endif

   // Two results carrying the same ROB tag in one cycle means a producer bug upstream.
   always_ff @(posedge clk) begin
      if (reset_n && !kill) begin
         for (int a = 0; a < NUM_REQ; a++) begin
            for (int b = a + 1; b < NUM_REQ; b++) begin
               if (grant[a] && grant[b])
                  assert (tag_of(req_data[a]) != tag_of(req_data[b]));
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed table-driven bench for cdb_arbiter (CDB_ARB_PERF_EN adds counter tests)
module tb_cdb_arbiter;
   import cdb_pkg::*;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     kill;
   logic [5:0]               req_valid;
   logic [5:0][CDB_W-1:0]    req_data;
   logic [5:0]               req_ready;
   logic [2:0][CDB_W-1:0]    cdb_out;
   logic [2:0]               cdb_valid;
`ifdef CDB_ARB_PERF_EN
   logic [5:0][15:0]         perf_stall_cnt;
`endif

   cdb_arbiter #(.NUM_REQ(6), .NUM_CDB(3)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .kill           (kill),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .cdb_out        (cdb_out),
      .cdb_valid      (cdb_valid)
`ifdef CDB_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] valid;
      logic       kill;
      logic [5:0] ready;
      logic [2:0] cvalid;
      logic [2:0] b0;
      logic [2:0] b1;
      logic [2:0] b2;
   } vec_t;

   vec_t vecs [13];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] v, input logic k, input logic [5:0] r,
                               input logic [2:0] cv, input int x0, input int x1, input int x2);
      vec_t t;
      t.valid = v; t.kill = k; t.ready = r; t.cvalid = cv;
      t.b0 = 3'(x0); t.b1 = 3'(x1); t.b2 = 3'(x2);
      return t;
   endfunction

   function automatic logic [CDB_W-1:0] word_of(input int i);
      if (i == 3) return {6'd17, 32'hDEADBEEF};
      return {6'(10 + i), 32'hA000_0000 + 32'(i) * 32'h111};
   endfunction

   task automatic chk_bus(input string nm, input int k, input logic cv, input int who);
      logic [CDB_W-1:0] exp;
      exp = cv ? word_of(who) : '0;
      chk($sformatf("%s bus%0d", nm, k), 64'(cdb_out[k]), 64'(exp));
   endtask

   initial begin
      reset_n   = 1'b0;
      kill      = 1'b0;
      req_valid = 6'h3F;
      for (int i = 0; i < 6; i++) req_data[i] = word_of(i);

      // pointer trace: 0 ->3 ->0 ->3 (kill holds) ->0 ->0 ->4 ->2 ->5 ->1 ->1 (kill) ->5
      vecs[0]  = mk(6'b111111, 1'b0, 6'b000111, 3'b111, 0, 1, 2);
      vecs[1]  = mk(6'b111111, 1'b0, 6'b111000, 3'b111, 3, 4, 5);
      vecs[2]  = mk(6'b111111, 1'b0, 6'b000111, 3'b111, 0, 1, 2);
      vecs[3]  = mk(6'b111111, 1'b1, 6'b000000, 3'b000, 0, 0, 0);
      vecs[4]  = mk(6'b111111, 1'b0, 6'b111000, 3'b111, 3, 4, 5);
      vecs[5]  = mk(6'b000000, 1'b0, 6'b000000, 3'b000, 0, 0, 0);
      vecs[6]  = mk(6'b001000, 1'b0, 6'b001000, 3'b001, 3, 0, 0);
      vecs[7]  = mk(6'b110010, 1'b0, 6'b110010, 3'b111, 4, 5, 1);
      vecs[8]  = mk(6'b111111, 1'b0, 6'b011100, 3'b111, 2, 3, 4);
      vecs[9]  = mk(6'b100001, 1'b0, 6'b100001, 3'b011, 5, 0, 0);
      vecs[10] = mk(6'b000101, 1'b0, 6'b000101, 3'b011, 2, 0, 0);
      vecs[11] = mk(6'b000001, 1'b1, 6'b000000, 3'b000, 0, 0, 0);
      vecs[12] = mk(6'b010010, 1'b0, 6'b010010, 3'b011, 1, 4, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 64'(req_ready), 64'h0);
      chk("reset cdb_valid", 64'(cdb_valid), 64'h0);
      for (int k = 0; k < 3; k++) chk_bus("reset", k, 1'b0, 0);
      reset_n = 1'b1;

      for (int v = 0; v < 13; v++) begin
         if (v != 0) @(negedge clk);
         req_valid = vecs[v].valid;
         kill      = vecs[v].kill;
         #1;
         chk($sformatf("v%0d req_ready", v), 64'(req_ready), 64'(vecs[v].ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d cdb_valid", v), 64'(cdb_valid), 64'(vecs[v].cvalid));
         chk_bus($sformatf("v%0d", v), 0, vecs[v].cvalid[0], int'(vecs[v].b0));
         chk_bus($sformatf("v%0d", v), 1, vecs[v].cvalid[1], int'(vecs[v].b1));
         chk_bus($sformatf("v%0d", v), 2, vecs[v].cvalid[2], int'(vecs[v].b2));
      end

      // pointer is at 5: all valid grants 5,0,1, then an async reset clears outputs mid-cycle
      @(negedge clk);
      req_valid = 6'h3F;
      kill      = 1'b0;
      #1;
      chk("wrap5 req_ready", 64'(req_ready), 64'b100011);
      @(posedge clk);
      #1;
      chk_bus("wrap5", 0, 1'b1, 5);
      chk_bus("wrap5", 2, 1'b1, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async cdb_valid", 64'(cdb_valid), 64'h0);
      chk_bus("async", 0, 1'b0, 0);
      chk("async req_ready", 64'(req_ready), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post-reset req_ready", 64'(req_ready), 64'b000111);
      @(posedge clk);
      #1;
      chk_bus("post-reset", 0, 1'b1, 0);
      chk_bus("post-reset", 2, 1'b1, 2);

`ifdef CDB_ARB_PERF_EN
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 6'h0;
      #1;
      chk("perf reset", 64'(perf_stall_cnt[5]), 64'h0);
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c != 0) @(negedge clk);
         req_valid = 6'h3F;
      end
      @(negedge clk);
      req_valid = 6'h0;
      #1;
      for (int i = 0; i < 6; i++)
         chk($sformatf("perf cnt%0d", i), 64'(perf_stall_cnt[i]), 64'd5);
      req_valid = 6'b100000;
      kill      = 1'b1;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      chk("perf sat5", 64'(perf_stall_cnt[5]), 64'hFFFF);
      chk("perf hold0", 64'(perf_stall_cnt[0]), 64'd5);
      kill      = 1'b0;
      req_valid = 6'h0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
